// File: rtl/ab_regs.sv
// ab_regs: accumulator A and register B sharing a tri-state data bus,
// with an optional carry/zero flag register (compiled in by FLAGS_EN).
// Loads and flag updates take effect on the rising CLK.
// CLR_n clears all state asynchronously. Without FLAGS_EN, CF and ZF are tied to 0.
module ab_regs (
  input  logic       CLK,
  input  logic       CLR_n,
  inout  wire  [7:0] DBUS,
  input  logic       La,
  input  logic       Ea,
  input  logic       Lb,
  input  logic       Su,
  input  logic       Fu,
  output logic [7:0] ina,
  output logic [7:0] inb,
  output logic       CF,
  output logic       ZF
);

  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;

  // Next-state values for A and B. With Ea=1, DBUS carries A, so La reloads A with its own value.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (La) a_d = DBUS;
    if (Lb) b_d = DBUS;
  end

  // A and B registers. Reset wins over any load on the same edge.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      a_q <= 8'h00;
      b_q <= 8'h00;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // The ALU operands come straight from the registers, with no combinational path from DBUS.
  assign ina = a_q;
  assign inb = b_q;

  // Tri-state drive of A onto the shared bus. This follows Ea even during reset.
  assign DBUS = Ea ? a_q : 8'bzzzz_zzzz;

`ifdef FLAGS_EN
  logic [8:0] alu_res;
  logic       cf_q, cf_d;
  logic       zf_q, zf_d;

  // 9-bit add or subtract. Subtraction is two's complement, so bit 8 means "no borrow".
  always_comb begin
    alu_res = {1'b0, a_q} + {1'b0, (Su ? ~b_q : b_q)} + {8'd0, Su};
    cf_d    = cf_q;
    zf_d    = zf_q;
    if (Fu) begin
      cf_d = alu_res[8];
      zf_d = (alu_res[7:0] == 8'h00);
    end
  end

  // Flag register. It samples the pre-edge operands, so a simultaneous load does not affect it.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      cf_q <= 1'b0;
      zf_q <= 1'b0;
    end else begin
      cf_q <= cf_d;
      zf_q <= zf_d;
    end
  end

  assign CF = cf_q;
  assign ZF = zf_q;
`else
  // No flag state is built: Su and Fu are unused, and the flags read as 0.
  logic unused_flag_ctrl;
  assign unused_flag_ctrl = Su ^ Fu;
  assign CF = 1'b0;
  assign ZF = 1'b0;
`endif

endmodule

// File: doc/ab_regs.md
AB_REGS -- requirements
Module: ab_regs

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
- CLK  input  1  system clock; all state changes on the rising edge.
- CLR_n  input  1  asynchronous, active-low reset.
REQ-002 DBUS  inout  8  shared data bus; read by both registers, driven by A when Ea=1.
REQ-003 La  input  1  load Accumulator A from DBUS at the next rising CLK.
REQ-004 Ea  input  1  drive A onto DBUS; when 0, the block's DBUS drive is 8'bzzzz_zzzz.
REQ-005 Lb  input  1  load Register B from DBUS at the next rising CLK.
REQ-006 Su  input  1  ALU operation (0=add, 1=sub); used for flag computation only.
REQ-007 Fu  input  1  update the flag register at the next rising CLK.
REQ-008 ina  output  8  current A contents, feeding the ALU.
REQ-009 inb  output  8  current B contents, feeding the ALU.
REQ-010 CF  output  1  carry/no-borrow flag.
REQ-011 ZF  output  1  zero flag.

Function
REQ-012 A SHALL capture DBUS on a rising CLK with La=1 and hold its value otherwise; B SHALL behave the same with Lb.
REQ-013 ina and inb SHALL be driven directly by the A and B registers, with no combinational path from DBUS.
REQ-014 DBUS SHALL equal A combinationally while Ea=1, with zero-cycle latency from Ea.
REQ-015 La=1 and Ea=1 in the same cycle SHALL leave A unchanged, since A reloads its own value.
REQ-016 La=1 and Lb=1 in the same cycle SHALL load both registers with the same DBUS value.
REQ-017 On a rising CLK with Fu=1, a 9-bit result SHALL be formed from the pre-edge ina and inb.
- Su=0: {1'b0,ina} + {1'b0,inb}.
- Su=1: {1'b0,ina} + {1'b0,~inb} + 1.
REQ-018 CF SHALL take result bit 8.
- Add: carry out.
- Sub: 1 when ina >= inb (no borrow).
REQ-019 ZF SHALL be 1 exactly when result[7:0] == 8'h00.
REQ-020 Fu=1 together with La and/or Lb SHALL compute flags from the pre-edge register values; the new loads SHALL become visible on ina/inb in the following cycle.
REQ-021 With Fu=0, CF and ZF SHALL hold their values.
REQ-022 Arithmetic SHALL wrap modulo 256 for ZF evaluation (for example, 8'hFF + 8'h01 gives ZF=1 and CF=1).

Reset
REQ-023 CLR_n=0 SHALL immediately clear A and B to 8'h00 and CF and ZF to 0, independent of CLK.
REQ-024 DBUS drive during reset SHALL follow Ea alone; with Ea=1 in reset, DBUS SHALL read 8'h00.
REQ-025 A load, or a flag update, whose edge coincides with CLR_n=0 SHALL be discarded.
REQ-026 The first load after CLR_n returns to 1 SHALL occur on the first rising CLK with La or Lb high.

Configuration
REQ-027 The macro FLAGS_EN SHALL compile the flag logic in or out.
- Defined: flag register and Fu behave per REQ-017..REQ-022.
- Undefined: no flag state exists, Fu is ignored, and CF and ZF are tied to 0.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset pulse mid-cycle with A=8'h5A and CF=1 -> ina=8'h00 and CF=0 before the next edge.
- DBUS=8'h2C, La=1, one edge -> ina=8'h2C; Ea=1 -> DBUS reads 8'h2C; Ea=0 -> block drives DBUS to z.
- A=8'hFF, B=8'h01, Su=0, Fu=1 -> CF=1, ZF=1; Su=1, Fu=1 -> CF=1, ZF=0.
- A=8'h03, B=8'h07, Su=1, Fu=1 -> CF=0, ZF=0; with A=B=8'h07 -> CF=1, ZF=1.
- Fu=1 and La=1 with DBUS=8'h00 and old A=B=8'h10, Su=1 -> ZF=1 from the old A, and ina=8'h00 on the next cycle.
- Build without FLAGS_EN, same stimulus as the third scenario -> CF=0 and ZF=0 throughout.
